// File: rtl/wb_arb_mux_pkg.sv
// wb_arb_mux_pkg: shared types and constants for the Wishbone arbiter/mux.
//   state_e   - arbiter FSM state (IDLE, GRANT, HOLD)
//   ARB_RR    - round-robin arbitration mode
//   ARB_FIXED - fixed-priority arbitration mode, lowest index wins
package wb_arb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

endpackage

// File: rtl/wb_arb_sel.sv
// wb_arb_sel: combinational winner selection for the Wishbone arbiter.
//   req   in  N   request vector (one bit per master)
//   last  in  LW  index of the previous owner (round-robin start point)
//   mode  in  1   ARB_RR or ARB_FIXED
//   grant out N   one-hot winner, all zero when nobody requests
//   valid out 1   at least one request is present
module wb_arb_sel
  import wb_arb_mux_pkg::*;
#(
  parameter  int N  = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic          found_s;
  logic [LW-1:0] idx_s;
  int            rot_s;

  // Scan candidates in priority order; the first requester found wins.
  always_comb begin
    grant   = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = {LW{1'b0}};
    rot_s   = 0;
    for (int i = 0; i < N; i++) begin
      // Round-robin starts the scan just after the previous owner.
      rot_s = (int'(last) + 1 + i) % N;
      if (mode == ARB_FIXED) begin
        idx_s = LW'(i);
      end else begin
        idx_s = LW'(rot_s);
      end
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/wb_arb_mux.sv
// wb_arb_mux: Wishbone B3 N-master to 1-slave multiplexer with registered grant.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_*_i                        flattened master buses, master m at [(m+1)*W-1 : m*W]
//   m_dat_o                      slave read data broadcast to every master
//   m_ack_o, m_err_o, m_rty_o    responses routed to the current owner only
//   s_*_o                        slave bus, driven from the owner in GRANT, else 0
//   s_dat_i, s_ack_i, s_err_i, s_rty_i  slave responses
//   bus_hold / bus_hold_ack      freeze request / frozen-with-no-owner indication
//   timeout_o                    one-cycle pulse when the response watchdog fires
module wb_arb_mux #(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ADDR_WIDTH*MASTERS-1:0]   m_adr_i,
  input  logic [DATA_WIDTH*MASTERS-1:0]   m_dat_i,
  input  logic [DATA_WIDTH/8*MASTERS-1:0] m_sel_i,
  input  logic [MASTERS-1:0]              m_cyc_i,
  input  logic [MASTERS-1:0]              m_stb_i,
  input  logic [MASTERS-1:0]              m_we_i,
  input  logic [3*MASTERS-1:0]            m_cti_i,
  input  logic [2*MASTERS-1:0]            m_bte_i,
  output logic [DATA_WIDTH*MASTERS-1:0]   m_dat_o,
  output logic [MASTERS-1:0]              m_ack_o,
  output logic [MASTERS-1:0]              m_err_o,
  output logic [MASTERS-1:0]              m_rty_o,
  output logic [ADDR_WIDTH-1:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic [DATA_WIDTH/8-1:0]         s_sel_o,
  output logic                            s_we_o,
  output logic [2:0]                      s_cti_o,
  output logic [1:0]                      s_bte_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_rty_i,
  input  logic                            bus_hold,
  output logic                            bus_hold_ack,
  output logic                            timeout_o
);

  import wb_arb_mux_pkg::*;

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int LW        = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  state_e               state_r;
  logic [MASTERS-1:0]   owner_r;
  logic [LW-1:0]        last_r;

  logic [MASTERS-1:0]   win_s;
  logic                 win_valid_s;
  logic                 arb_pt_s;
  logic                 grant_st_s;
  logic [MASTERS-1:0]   route_s;
  logic                 resp_any_s;
  logic                 wd_fire_s;

  function automatic logic [LW-1:0] oh_to_idx(input logic [MASTERS-1:0] oh);
    logic [LW-1:0] idx;
    idx = {LW{1'b0}};
    for (int i = 0; i < MASTERS; i++) begin
      if (oh[i]) begin
        idx = LW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  wb_arb_sel #(.N(MASTERS)) u_sel (
    .req   (m_cyc_i),
    .last  (last_r),
    .mode  ((ARB_MODE == 1) ? ARB_FIXED : ARB_RR),
    .grant (win_s),
    .valid (win_valid_s)
  );

  assign grant_st_s = (state_r == GRANT);
  // route_s is zero outside GRANT, so it gates both the slave bus and responses.
  assign route_s    = grant_st_s ? owner_r : {MASTERS{1'b0}};
  assign resp_any_s = s_ack_i | s_err_i | s_rty_i;

  // Decide whether this cycle may re-arbitrate the bus.
  always_comb begin
    case (state_r)
      IDLE:    arb_pt_s = 1'b1;
      GRANT:   arb_pt_s = ~|(m_cyc_i & owner_r);
      HOLD:    arb_pt_s = ~bus_hold;
      default: arb_pt_s = 1'b1;
    endcase
  end

  // Arbiter FSM: state, one-hot owner and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      owner_r <= {MASTERS{1'b0}};
      last_r  <= LW'(MASTERS - 1);
    end else if (arb_pt_s) begin
      if (bus_hold) begin
        state_r <= HOLD;
        owner_r <= {MASTERS{1'b0}};
      end else if (win_valid_s) begin
        state_r <= GRANT;
        owner_r <= win_s;
        last_r  <= oh_to_idx(win_s);
      end else begin
        state_r <= IDLE;
        owner_r <= {MASTERS{1'b0}};
      end
    end
  end

  // AND-OR multiplexer from the owner's slice onto the slave bus.
  always_comb begin
    s_adr_o = {ADDR_WIDTH{1'b0}};
    s_dat_o = {DATA_WIDTH{1'b0}};
    s_sel_o = {SEL_WIDTH{1'b0}};
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    for (int m = 0; m < MASTERS; m++) begin
      s_adr_o = s_adr_o | (m_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{route_s[m]}});
      s_dat_o = s_dat_o | (m_dat_i[m*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{route_s[m]}});
      s_sel_o = s_sel_o | (m_sel_i[m*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{route_s[m]}});
      s_we_o  = s_we_o | (m_we_i[m] & route_s[m]);
      s_cti_o = s_cti_o | (m_cti_i[m*3 +: 3] & {3{route_s[m]}});
      s_bte_o = s_bte_o | (m_bte_i[m*2 +: 2] & {2{route_s[m]}});
      s_cyc_o = s_cyc_o | (m_cyc_i[m] & route_s[m]);
      s_stb_o = s_stb_o | (m_stb_i[m] & route_s[m]);
    end
  end

  assign m_dat_o      = {MASTERS{s_dat_i}};
  assign m_ack_o      = route_s & {MASTERS{s_ack_i}};
  assign m_rty_o      = route_s & {MASTERS{s_rty_i}};
  assign m_err_o      = route_s & {MASTERS{s_err_i | wd_fire_s}};
  assign bus_hold_ack = (state_r == HOLD);
  assign timeout_o    = wd_fire_s;

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_r;

      // A genuine slave response in the firing cycle suppresses the error.
      assign wd_fire_s = grant_st_s & s_stb_o & ~resp_any_s & (cnt_r == CW'(TIMEOUT - 1));

      // Count strobed cycles that are still waiting for a slave response.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_r <= {CW{1'b0}};
        end else if (wd_fire_s) begin
          cnt_r <= {CW{1'b0}};
        end else if (grant_st_s && s_stb_o && !resp_any_s) begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_r <= {CW{1'b0}};
        end
      end
    end else begin : g_no_wd
      assign wd_fire_s = 1'b0;
    end
  endgenerate

endmodule
